ro_freq_meter: RTL and testbench

RO_FREQ_METER -- requirements
Module: ro_freq_meter

---
 rtl/ro_freq_meter.sv | 223 ++++++++++++++++++++++
 tb/tb_ro_freq_meter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ro_freq_meter.sv
`default_nettype none
// ============================================================================
//  Module   : ro_freq_meter
//  Brief    : Ring-oscillator frequency meter. Synchronizes NUM_CH async probe
//             taps, settles on the selected channel, counts rising edges over a
//             programmable window and presents the result with a valid/ready
//             handshake. Supports back-to-back continuous measurements.
//  Options  : RO_FREQ_METER_OVF_SAT_EN - saturate the edge counter and report
//             overflow on ovf_o (default build wraps and ties ovf_o low).
//  Revision : 1.0 - initial release
// ============================================================================
module ro_freq_meter #(
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int WIN_W       = 16,
    parameter int CNT_W       = 20
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [NUM_CH-1:0]         probe_i,
    input  logic [$clog2(NUM_CH)-1:0] ch_sel_i,
    input  logic [WIN_W-1:0]          win_len_i,
    input  logic                      start_i,
    input  logic                      continuous_i,
    input  logic                      stop_i,
    output logic                      busy_o,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic [CNT_W-1:0]          count_o,
    output logic [$clog2(NUM_CH)-1:0] ch_o,
    output logic                      ovf_o
);

    localparam int                SEL_W       = $clog2(NUM_CH);
    localparam int                SET_W       = $clog2(SYNC_STAGES + 2);
    localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SYNC_STAGES);
    localparam logic [SEL_W:0]    NUM_CH_EXT  = (SEL_W + 1)'(NUM_CH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        COUNT  = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic [NUM_CH-1:0]   rise;
    logic [SEL_W-1:0]    ch_q;
    logic [WIN_W-1:0]    win_q;
    logic [WIN_W-1:0]    rem_q;
    logic [SET_W-1:0]    settle_cnt;
    logic [CNT_W-1:0]    cnt_q;
    logic                cont_q;
    logic                cont_eff;
    logic                ch_ok;
    logic                rise_sel;
    logic                enter_count;

    // Per-channel synchronizer chain plus one delay flop for edge detection
    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_sync
            logic [SYNC_STAGES-1:0] chain;
            logic                   prev;

            // Shift the async tap through the synchronizer, keep last value
            always_ff @(posedge clk_i) begin
                if (reset_i) begin
                    chain <= '0;
                    prev  <= 1'b0;
                end else begin
                    chain <= {chain[SYNC_STAGES-2:0], probe_i[g]};
                    prev  <= chain[SYNC_STAGES-1];
                end
            end

            assign rise[g] = chain[SYNC_STAGES-1] & ~prev;
        end
    endgenerate

    // Out-of-range channel requests fall back to channel 0
    assign ch_ok       = ({1'b0, ch_sel_i} < NUM_CH_EXT);
    assign rise_sel    = rise[ch_q];
    // A stop in the same cycle as the HOLD handshake already ends the run
    assign cont_eff    = cont_q & ~stop_i;
    assign enter_count = (state_nxt == COUNT) && (state != COUNT);

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and status outputs
    always_comb begin
        state_nxt = state;
        busy_o    = 1'b1;
        valid_o   = 1'b0;
        case (state)
            IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                // SYNC_STAGES+1 cycles flushes the previous channel's edges
                if (settle_cnt == SETTLE_LAST) begin
                    state_nxt = COUNT;
                end
            end
            COUNT: begin
                if (rem_q == '0) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                valid_o = 1'b1;
                if (ready_i) begin
                    state_nxt = cont_eff ? COUNT : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef RO_FREQ_METER_OVF_SAT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    logic ovf_q;

    // Capture request, run settle/window counters, saturating edge counter
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ch_q       <= '0;
            win_q      <= '0;
            rem_q      <= '0;
            settle_cnt <= '0;
            cnt_q      <= '0;
            cont_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            if ((state == IDLE) && start_i) begin
                ch_q       <= ch_ok ? ch_sel_i : '0;
                win_q      <= (win_len_i == '0) ? WIN_W'(1) : win_len_i;
                cont_q     <= continuous_i;
                settle_cnt <= '0;
            end else begin
                if (stop_i && (state != IDLE)) begin
                    cont_q <= 1'b0;
                end
                if (state == SETTLE) begin
                    settle_cnt <= settle_cnt + 1'b1;
                end
            end
            if (enter_count) begin
                cnt_q <= '0;
                ovf_q <= 1'b0;
                rem_q <= win_q - 1'b1;
            end else if (state == COUNT) begin
                rem_q <= rem_q - 1'b1;
                if (rise_sel) begin
                    if (cnt_q == CNT_MAX) begin
                        ovf_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            end
        end
    end

    assign ovf_o = ovf_q & valid_o;
`else
    // Capture request, run settle/window counters, wrapping edge counter
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ch_q       <= '0;
            win_q      <= '0;
            rem_q      <= '0;
            settle_cnt <= '0;
            cnt_q      <= '0;
            cont_q     <= 1'b0;
        end else begin
            if ((state == IDLE) && start_i) begin
                ch_q       <= ch_ok ? ch_sel_i : '0;
                win_q      <= (win_len_i == '0) ? WIN_W'(1) : win_len_i;
                cont_q     <= continuous_i;
                settle_cnt <= '0;
            end else begin
                if (stop_i && (state != IDLE)) begin
                    cont_q <= 1'b0;
                end
                if (state == SETTLE) begin
                    settle_cnt <= settle_cnt + 1'b1;
                end
            end
            if (enter_count) begin
                cnt_q <= '0;
                rem_q <= win_q - 1'b1;
            end else if (state == COUNT) begin
                rem_q <= rem_q - 1'b1;
                if (rise_sel) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign ovf_o = 1'b0;
`endif

    assign count_o = cnt_q;
    assign ch_o    = ch_q;

endmodule
`default_nettype wire

// File: tb/tb_ro_freq_meter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ro_freq_meter
//  Brief    : Self-checking bench for ro_freq_meter (NUM_CH=3, CNT_W=4).
//             Table vectors with fixed expectations, directed multi-cycle
//             sequences and random probes checked against a sample-history
//             edge-count model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ro_freq_meter;

    localparam int NCH  = 3;
    localparam int SYNC = 2;
    localparam int CW   = 4;
    localparam int HMSK = 8191;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic [2:0]  probe = 3'b000;
    logic [1:0]  ch_sel = 2'd0;
    logic [15:0] win_len = 16'd0;
    logic        start = 1'b0;
    logic        continuous = 1'b0;
    logic        stop = 1'b0;
    logic        ready = 1'b0;
    logic        busy;
    logic        valid;
    logic [3:0]  count;
    logic [1:0]  ch;
    logic        ovf;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [2:0] hist [0:HMSK];
    int  half [3];
    int  ph [3];
    bit  rand_mode = 1'b0;

    ro_freq_meter #(
        .NUM_CH(NCH), .SYNC_STAGES(SYNC), .WIN_W(16), .CNT_W(CW)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .probe_i(probe), .ch_sel_i(ch_sel),
        .win_len_i(win_len), .start_i(start), .continuous_i(continuous),
        .stop_i(stop), .busy_o(busy), .valid_o(valid), .ready_i(ready),
        .count_o(count), .ch_o(ch), .ovf_o(ovf)
    );

    always #5 clk = ~clk;

    // Record the probe value seen at each rising edge
    always @(posedge clk) begin
        cyc = cyc + 1;
        hist[cyc & HMSK] = probe;
    end

    // Probe generator: fixed half-periods per channel, or random bits
    always @(negedge clk) begin
        for (int c = 0; c < 3; c++) begin
            if (rand_mode) begin
                probe[c] = 1'($urandom);
            end else if (half[c] == 0) begin
                probe[c] = 1'b0;
                ph[c] = 0;
            end else begin
                ph[c] = ph[c] + 1;
                if (ph[c] >= half[c]) begin
                    ph[c] = 0;
                    probe[c] = ~probe[c];
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Rising transitions of the selected tap between samples e0+1 .. e0+n+1:
    // the window of n cycles, seen through the synchronizer delay.
    function automatic int model_count(input int e0, input int n, input int c);
        int r = 0;
        for (int j = e0 + 2; j <= e0 + n + 1; j++) begin
            if (hist[j & HMSK][c] && !hist[(j - 1) & HMSK][c]) r++;
        end
        return r;
    endfunction

    task automatic set_halves(input int a, input int b, input int c);
        half[0] = a; half[1] = b; half[2] = c;
    endtask

    task automatic measure(input logic [1:0] s, input logic [15:0] w, input int hold,
                           input bit poke, input bit use_model,
                           input int exp_ch_i, input int exp_cnt_i, input bit exp_ovf_i);
        int  e0, n, raw, exp_ch, exp_cnt;
        bit  got, exp_ovf, stable;
        logic [3:0] c0;
        logic [1:0] h0;
        n = (w == 0) ? 1 : int'(w);
        exp_ch = exp_ch_i; exp_cnt = exp_cnt_i; exp_ovf = exp_ovf_i;
        @(negedge clk);
        ch_sel = s; win_len = w; start = 1'b1;
        @(negedge clk);
        start = 1'b0; e0 = cyc;
        ch_sel = 2'($urandom); win_len = 16'($urandom);
        check("busy_after_start", 32'(busy), 32'd1);
        got = 1'b0;
        for (int t = 0; t < n + SYNC + 10; t++) begin
            if (valid) begin got = 1'b1; break; end
            start = poke && (t == 1 || t == SYNC + 2 + n / 2);
            @(negedge clk);
        end
        start = 1'b0;
        if (!got) begin
            check("valid_timeout", 32'd0, 32'd1);
            return;
        end
        check("latency", 32'(cyc - e0), 32'(SYNC + 1 + n));
        if (use_model) begin
            raw = model_count(e0, n, (s >= 2'd3) ? 0 : int'(s));
            exp_ch = (s >= 2'd3) ? 0 : int'(s);
`ifdef RO_FREQ_METER_OVF_SAT_EN
            exp_cnt = (raw > 15) ? 15 : raw;
            exp_ovf = (raw > 15);
`else
            exp_cnt = raw % 16;
            exp_ovf = 1'b0;
`endif
        end
        check("count", 32'(count), 32'(exp_cnt));
        check("ch", 32'(ch), 32'(exp_ch));
        check("ovf", 32'(ovf), 32'(exp_ovf));
        c0 = count; h0 = ch;
        if (hold > 0) begin
            stable = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if (!(valid === 1'b1 && count === c0 && ch === h0 && ovf === exp_ovf))
                    stable = 1'b0;
            end
            check("hold_stable", 32'(stable), 32'd1);
        end
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        check("idle_after_ready", 32'({busy, valid}), 32'd0);
    endtask

    typedef struct {
        logic [1:0]  s;
        logic [15:0] w;
        int h0, h1, h2;
        int hold;
        bit poke;
        int exp_ch;
        int exp_cnt;
        bit exp_ovf;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int  e0, c_rdy;
        bit  got, quiet;

        vecs[0] = '{2'd1, 16'd64,  0, 4, 0, 20, 1'b0, 1, 8, 1'b0};
        vecs[1] = '{2'd3, 16'd32,  2, 8, 0,  0, 1'b0, 0, 8, 1'b0};
        vecs[2] = '{2'd2, 16'd0,   0, 0, 0,  1, 1'b1, 2, 0, 1'b0};
        vecs[3] = '{2'd0, 16'd40,  5, 1, 1,  2, 1'b1, 0, 4, 1'b0};
        vecs[4] = '{2'd2, 16'd24,  1, 1, 3,  0, 1'b0, 2, 4, 1'b0};
`ifdef RO_FREQ_METER_OVF_SAT_EN
        vecs[5] = '{2'd1, 16'd100, 0, 1, 0,  3, 1'b0, 1, 15, 1'b1};
`else
        vecs[5] = '{2'd1, 16'd100, 0, 1, 0,  3, 1'b0, 1, 2, 1'b0};
`endif
        set_halves(0, 0, 0);
        for (int c = 0; c < 3; c++) ph[c] = 0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({valid, busy, count, ch, ovf}), 32'd0);
        reset_i = 1'b0;
        @(negedge clk);

        // Table vectors
        for (int i = 0; i < 6; i++) begin
            set_halves(vecs[i].h0, vecs[i].h1, vecs[i].h2);
            measure(vecs[i].s, vecs[i].w, vecs[i].hold, vecs[i].poke, 1'b0,
                    vecs[i].exp_ch, vecs[i].exp_cnt, vecs[i].exp_ovf);
        end

        // Continuous mode: three results then stop
        set_halves(0, 0, 2);
        @(negedge clk);
        ch_sel = 2'd2; win_len = 16'd16; continuous = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; continuous = 1'b0; e0 = cyc; c_rdy = 0;
        for (int r = 0; r < 3; r++) begin
            got = 1'b0;
            for (int t = 0; t < 40; t++) begin
                if (valid) begin got = 1'b1; break; end
                @(negedge clk);
            end
            if (!got) begin
                check("cont_timeout", 32'd0, 32'd1);
                break;
            end
            if (r == 0) check("cont_latency", 32'(cyc - e0), 32'(SYNC + 1 + 16));
            else        check("cont_gap", 32'(cyc - c_rdy), 32'd17);
            check("cont_count", 32'(count), 32'd4);
            check("cont_ch", 32'(ch), 32'd2);
            ready = 1'b1; c_rdy = cyc;
            @(negedge clk);
            ready = 1'b0;
            if (r < 2) begin
                check("cont_rearm", 32'({busy, valid}), 32'b10);
                if (r == 1) begin
                    stop = 1'b1;
                    @(negedge clk);
                    stop = 1'b0;
                end
            end else begin
                check("cont_idle", 32'({busy, valid}), 32'd0);
            end
        end
        quiet = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
        end
        check("cont_stopped", 32'(quiet), 32'd1);

        // Reset in the middle of a window
        set_halves(0, 4, 0);
        @(negedge clk);
        ch_sel = 2'd1; win_len = 16'd64; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        check("busy_mid_count", 32'(busy), 32'd1);
        reset_i = 1'b1;
        @(negedge clk);
        check("reset_mid_count", 32'({valid, busy, count, ch, ovf}), 32'd0);
        reset_i = 1'b0;
        quiet = 1'b1;
        repeat (80) begin
            @(negedge clk);
            if (valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
        end
        check("no_result_after_reset", 32'(quiet), 32'd1);
        measure(2'd1, 16'd64, 0, 1'b0, 1'b0, 1, 8, 1'b0);

        // Random probes against the sample-history model
        rand_mode = 1'b1;
        for (int i = 0; i < 25; i++) begin
            measure(2'($urandom), 16'($urandom_range(0, 40)), $urandom_range(0, 3),
                    1'($urandom), 1'b1, 0, 0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
